// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin strobe arbiter.
package arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] sel);
    onehot8      = '0;
    onehot8[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: routes in to the output selected by sel, others low.
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request at or after i_ptr, wrapping.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = i_ptr + SEL_W'(i);
      if (!o_any && i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared strobe path,
// with a hold limit and a mandatory idle bubble between grants.
module dmux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             strobe_in,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [NREQ-1:0]  strobe_out,
  output logic             timeout
);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_strobe_gated;

  rr_pick8 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_winner;
          w_grant_nxt = onehot8(w_winner);
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // Both release kinds share the path; timeout marks only the forced one.
        if (!req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD - 1))) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_ptr_nxt     = r_sel + 3'd1;
          w_timeout_nxt = req[r_sel];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  assign grant          = r_grant;
  assign sel            = r_sel;
  assign busy           = (r_state == GRANT);
  assign timeout        = r_timeout;
  assign w_strobe_gated = strobe_in & busy;

  DMux8Way u_dmux (
    .in  (w_strobe_gated),
    .sel (r_sel),
    .a   (strobe_out[0]),
    .b   (strobe_out[1]),
    .c   (strobe_out[2]),
    .d   (strobe_out[3]),
    .e   (strobe_out[4]),
    .f   (strobe_out[5]),
    .g   (strobe_out[6]),
    .h   (strobe_out[7])
  );

endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Scoreboard bench for dmux8_rr_arbiter: a request-level reference model feeds
// an expectation queue that a per-cycle monitor drains and compares.
module tb_dmux8_rr_arbiter;

  localparam int unsigned MAXH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = '0;
  logic       strobe_in = 1'b0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] strobe_out;
  logic       timeout;

  dmux8_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .strobe_in  (strobe_in),
    .grant      (grant),
    .sel        (sel),
    .busy       (busy),
    .strobe_out (strobe_out),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
    logic [7:0] strobe;
  } exp_t;

  exp_t q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit mon_en = 1'b0;

  // Reference model: who holds the grant, for how many cycles, and where the search starts next.
  bit m_busy = 1'b0;
  int m_sel = 0;
  int m_ptr = 0;
  int m_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic [7:0] r, output bit to);
    to = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (r[idx]) begin
          m_sel  = idx;
          m_busy = 1'b1;
          m_hold = 1;
          break;
        end
      end
    end else if (!r[m_sel]) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 8;
    end else if (m_hold == int'(MAXH)) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 8;
      to     = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic cycle(input logic [7:0] r, input logic s);
    exp_t e;
    bit   to;
    @(negedge clk);
    reset     = 1'b0;
    req       = r;
    strobe_in = s;
    mon_en    = 1'b1;
    model_step(r, to);
    e.grant   = m_busy ? 8'(1 << m_sel) : 8'h00;
    e.sel     = 3'(m_sel);
    e.busy    = m_busy;
    e.timeout = to;
    e.strobe  = (s && m_busy) ? e.grant : 8'h00;
    q.push_back(e);
  endtask

  task automatic mid_reset(input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    req       = r;
    strobe_in = 1'b1;
    #2 reset  = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_sel", sel, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_timeout", timeout, 0);
    chk("async_rst_strobe", strobe_out, 0);
    m_busy = 1'b0;
    m_ptr  = 0;
    m_hold = 0;
    e = '{grant: 8'h00, sel: 3'd0, busy: 1'b0, timeout: 1'b0, strobe: 8'h00};
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL queue_underrun: no expectation for cycle at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("grant", grant, e.grant);
        chk("busy", busy, e.busy);
        chk("timeout", timeout, e.timeout);
        chk("strobe_out", strobe_out, e.strobe);
        if (e.busy) chk("sel", sel, e.sel);
        chk("onehot0_grant", $onehot0(grant), 1);
        chk("busy_eq_or_grant", busy, |grant);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur;
    #1 reset = 1'b1;
    #2;
    chk("reset_grant", grant, 0);
    chk("reset_sel", sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_strobe", strobe_out, 0);

    repeat (3) cycle(8'h04, 1'b0);
    cycle(8'h00, 1'b0);
    repeat (3) cycle(8'h09, 1'b0);
    cycle(8'h00, 1'b0);

    for (int i = 0; i < 45; i++) cycle(8'hFF, 1'($urandom_range(0, 1)));
    repeat (2) cycle(8'h00, 1'b0);

    cycle(8'h20, 1'b0);
    cycle(8'h00, 1'b0);
    repeat (12) cycle(8'h21, 1'b0);
    cycle(8'h00, 1'b0);

    cycle(8'h08, 1'b0);
    for (int i = 0; i < 6; i++) cycle(8'h08, 1'(i));
    repeat (2) cycle(8'h00, 1'b1);

    repeat (3) cycle(8'h02, 1'b0);
    mid_reset(8'h02);
    repeat (4) cycle(8'h82, 1'b0);
    cycle(8'h00, 1'b0);

    repeat (2) cycle(8'h80, 1'b0);
    repeat (2) cycle(8'h01, 1'b0);
    cycle(8'h81, 1'b0);
    repeat (3) cycle(8'h80, 1'b0);
    cycle(8'h00, 1'b0);

    cur = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
      if ($urandom_range(0, 9) == 0) cur = 8'h00;
      if ($urandom_range(0, 59) == 0) mid_reset(cur);
      else cycle(cur, 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmux8_rr_arbiter.md
Name: dmux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-way demultiplexed strobe path among 8 requesters.
- Grants one requester at a time and holds the grant until the requester releases it or a hold limit expires.
- Drives a registered 3-bit select and a one-hot grant vector.
- Routes the shared 1-bit strobe through the existing DMux8Way to the granted requester only.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may last. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i = requester i.
- strobe_in  input  1  shared strobe to be routed to the current grantee.
- grant  output  8  one-hot grant, registered; all zero when idle.
- sel  output  3  index of the current grantee, registered. Meaningful only while busy = 1.
- busy  output  1  high while in GRANT.
- strobe_out  output  8  strobe_in demultiplexed by sel, forced to zero when busy = 0 (combinational).
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE, grant = 0, sel = 0, busy = 0, timeout = 0, priority pointer ptr = 0, hold_cnt = 0. strobe_out = 0.
- States:
  - IDLE: no grant.
  - GRANT: grant[sel] = 1, busy = 1.
- IDLE transitions:
  - If req == 0: stay in IDLE.
  - Otherwise: winner = first set bit of req, searching ptr, ptr+1, … wrapping modulo 8.
  - On the next edge: sel = winner, grant = one-hot(winner), busy = 1, hold_cnt = 0, go to GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT transitions, evaluated each edge:
  - Voluntary release: req[sel] = 0. Go to IDLE, grant = 0, busy = 0, ptr = sel+1 mod 8, timeout = 0.
  - Forced release: req[sel] = 1 and hold_cnt == MAX_HOLD-1. Go to IDLE, grant = 0, busy = 0, ptr = sel+1 mod 8, timeout = 1 for exactly that one following cycle.
  - Otherwise: hold_cnt increments and the grant is held.
  - Maximum grant length is therefore MAX_HOLD cycles.
- Mandatory one-cycle IDLE bubble between consecutive grants, even if other requests are pending. Arbitration for the next grant happens in that bubble cycle.
- Changes to req bits other than req[sel] during GRANT have no effect on the grant.
- Wrap-around: sel = 7 on release gives ptr = 0.
- Fairness: with all 8 bits of req held high, grants rotate 0, 1, …, 7, 0, … with no requester skipped.
- A requester whose req is still high after a forced release is eligible again only after all higher-rotation requesters have been served.
- strobe_out[i] = strobe_in & busy & (sel == i). Zero latency from strobe_in; no glitch on bits other than sel while sel is stable.
- grant and sel never change except at a state transition.
- Reset asserted mid-grant: all outputs drop to reset values immediately; ptr returns to 0.
- Invariant checked by assertions: $onehot0(grant), and busy == |grant.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, GRANT};
  - localparams NREQ = 8 and SEL_W = 3;
  - function onehot8(sel) returning the one-hot grant vector.
- One new sub-module, rr_pick8: purely combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: winner[2:0], any.
- Strobe routing instantiates the existing DMux8Way, with its input gated by busy.
- Remaining logic (state register, ptr, hold counter, timeout) lives in the top module.

Test Plan:
- Reset, then req = 8'b0000_0100 held → grant = 8'h04, sel = 2, busy = 1 one cycle after req is sampled. Release req → grant = 0 on the next edge, ptr = 3.
- req = 8'hFF held forever, MAX_HOLD = 4 → grants 0, 1, 2, …, 7, 0 in sequence. Each grant lasts 4 cycles with timeout pulsing once per grant, separated by 1 idle cycle (period 5 cycles).
- ptr = 6 (after granting 5) and req = 8'b0010_0001 → winner 0, not 5. Next arbitration with the same req → 5.
- During a grant to 3, toggle strobe_in 1/0 → strobe_out = 8'h08 / 8'h00. With busy = 0 and strobe_in = 1 → strobe_out = 8'h00.
- req[1] high and granted, then reset asserted mid-cycle → grant, sel, busy drop asynchronously before the next clk edge. After release with req = 8'h82 → grant to 1 (ptr reset to 0).
- req[7] granted and dropped, with req = 8'h81 still pending → bubble cycle, then grant to 0 (wrap-around), then 7 after 0 releases.
